fp_cc_unit: RTL and testbench

Floating-point condition-code unit sitting directly downstream of `fp_comparator`. It registers the comparator's eq/lt/le flags for c.eq.s / c.lt.s / c.le.s, writes the selected bit of an 8-entry condition-code register (FCSR cc[7:0]), and resolves bc1t/bc1f branch queries against it. A stall handshake guards the read-after-write hazard on a cc bit that is still in flight.

---
 rtl/fp_cc_unit.sv | 98 +++++++++
 tb/tb_fp_cc_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_cc_unit.sv
// Floating-point condition-code unit: registers comparator flags, writes FCSR cc bits,
// and resolves bc1t/bc1f branch queries with a read-after-write stall on in-flight bits.
module fp_cc_unit #(
  parameter int CC_BITS = 8,
  localparam int IDX_W = $clog2(CC_BITS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmp_valid,
  output logic               cmp_ready,
  input  logic [1:0]         cmp_op,
  input  logic [IDX_W-1:0]   cmp_cc,
  input  logic               eq,
  input  logic               lt,
  input  logic               gt,
  input  logic               le,
  input  logic               ge,
  input  logic               br_valid,
  output logic               br_ready,
  input  logic [IDX_W-1:0]   br_cc,
  input  logic               br_tf,
  output logic               br_resp_valid,
  output logic               br_taken,
  input  logic               flush,
  output logic [CC_BITS-1:0] cc_out
);

  typedef enum logic [1:0] {
    OP_EQ  = 2'b00,
    OP_LT  = 2'b01,
    OP_LE  = 2'b10,
    OP_RSV = 2'b11
  } cmp_op_e;

  logic               s1_valid;
  logic [IDX_W-1:0]   s1_cc;
  logic               s1_res;
  logic [CC_BITS-1:0] cc;
  logic               cmp_accept;
  logic               br_accept;
  logic               cmp_res;

  // gt/ge come with the comparator bundle but no supported compare needs them.
  logic unused_flags;
  assign unused_flags = gt | ge;

  assign cmp_ready  = ~flush;
  assign cmp_accept = cmp_valid & cmp_ready;
  assign br_ready   = ~flush & ~(s1_valid & (s1_cc == br_cc));
  assign br_accept  = br_valid & br_ready;
  assign cc_out     = cc;

  always_comb begin
    cmp_res = 1'b0;
    case (cmp_op_e'(cmp_op))
      OP_EQ:   cmp_res = eq;
      OP_LT:   cmp_res = lt;
      OP_LE:   cmp_res = le;
      default: cmp_res = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cc    <= '0;
      s1_res   <= 1'b0;
    end else if (cmp_accept) begin
      s1_valid <= 1'b1;
      s1_cc    <= cmp_cc;
      s1_res   <= cmp_res;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= '0;
    end else if (s1_valid && !flush) begin
      cc[s1_cc] <= s1_res;
    end
  end

  // Branches read cc before this edge's writeback, so a same-cycle compare is younger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_resp_valid <= 1'b0;
      br_taken      <= 1'b0;
    end else begin
      br_resp_valid <= br_accept;
      if (br_accept) begin
        br_taken <= cc[br_cc] ~^ br_tf;
      end
    end
  end

endmodule

// File: tb/tb_fp_cc_unit.sv
// Directed self-checking bench for fp_cc_unit: compares, branches, stalls, flush and async reset.
module tb_fp_cc_unit;

  logic       clk;
  logic       rst_n;
  logic       cmp_valid;
  logic       cmp_ready;
  logic [1:0] cmp_op;
  logic [2:0] cmp_cc;
  logic       eq, lt, gt, le, ge;
  logic       br_valid;
  logic       br_ready;
  logic [2:0] br_cc;
  logic       br_tf;
  logic       br_resp_valid;
  logic       br_taken;
  logic       flush;
  logic [7:0] cc_out;

  int n_compared = 0;
  int n_mismatched = 0;

  fp_cc_unit #(.CC_BITS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmp_valid    (cmp_valid),
    .cmp_ready    (cmp_ready),
    .cmp_op       (cmp_op),
    .cmp_cc       (cmp_cc),
    .eq           (eq),
    .lt           (lt),
    .gt           (gt),
    .le           (le),
    .ge           (ge),
    .br_valid     (br_valid),
    .br_ready     (br_ready),
    .br_cc        (br_cc),
    .br_tf        (br_tf),
    .br_resp_valid(br_resp_valid),
    .br_taken     (br_taken),
    .flush        (flush),
    .cc_out       (cc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic set_flags(input logic f_eq, input logic f_lt, input logic f_le);
    eq = f_eq;
    lt = f_lt;
    le = f_le;
    gt = ~f_le;
    ge = f_eq | ~f_lt;
  endtask

  initial begin
    rst_n = 1'b0; cmp_valid = 1'b0; cmp_op = 2'b00; cmp_cc = 3'd0;
    eq = 1'b0; lt = 1'b0; gt = 1'b0; le = 1'b0; ge = 1'b0;
    br_valid = 1'b0; br_cc = 3'd0; br_tf = 1'b0; flush = 1'b0;

    #12;
    check_value("reset_cc", cc_out, 8'h00);
    check_value("reset_resp_valid", {7'd0, br_resp_valid}, 8'h00);
    check_value("reset_taken", {7'd0, br_taken}, 8'h00);
    check_value("reset_cmp_ready", {7'd0, cmp_ready}, 8'h01);
    check_value("reset_br_ready", {7'd0, br_ready}, 8'h01);
    @(negedge clk); rst_n = 1'b1;

    // Compare LT 1.0 vs 2.0 into cc3
    @(negedge clk);
    cmp_valid = 1'b1; cmp_op = 2'b01; cmp_cc = 3'd3; set_flags(1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_value("lt_cc_not_yet", cc_out, 8'h00);
    @(negedge clk); cmp_valid = 1'b0;
    @(posedge clk); #1;
    check_value("lt_cc3_set", cc_out, 8'h08);

    // Compare EQ 2.0 vs 1.0 into cc3, then bc1t on cc3 stalls one cycle
    @(negedge clk);
    cmp_valid = 1'b1; cmp_op = 2'b00; cmp_cc = 3'd3; set_flags(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    cmp_valid = 1'b0; br_valid = 1'b1; br_cc = 3'd3; br_tf = 1'b1;
    #1;
    check_value("hazard_br_ready_low", {7'd0, br_ready}, 8'h00);
    @(posedge clk); #1;
    check_value("hazard_no_resp", {7'd0, br_resp_valid}, 8'h00);
    check_value("eq_cc3_cleared", cc_out, 8'h00);
    check_value("hazard_br_ready_high", {7'd0, br_ready}, 8'h01);
    @(posedge clk); #1;
    check_value("stall_resp_valid", {7'd0, br_resp_valid}, 8'h01);
    check_value("stall_taken", {7'd0, br_taken}, 8'h00);
    @(negedge clk); br_valid = 1'b0;
    @(posedge clk); #1;
    check_value("resp_one_cycle", {7'd0, br_resp_valid}, 8'h00);

    // Back-to-back: LE 1.0 vs 1.0 to cc0, LT -2.0 vs -1.0 to cc7
    @(negedge clk);
    cmp_valid = 1'b1; cmp_op = 2'b10; cmp_cc = 3'd0; set_flags(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmp_op = 2'b01; cmp_cc = 3'd7; set_flags(1'b0, 1'b1, 1'b1);
    #1;
    check_value("b2b_cmp_ready", {7'd0, cmp_ready}, 8'h01);
    @(posedge clk); #1;
    check_value("b2b_first_write", cc_out, 8'h01);
    @(negedge clk); cmp_valid = 1'b0;
    @(posedge clk); #1;
    check_value("b2b_both_written", cc_out, 8'h81);

    // Same-cycle compare EQ to cc5 and bc1f on cc5 with S1 empty
    @(negedge clk);
    cmp_valid = 1'b1; cmp_op = 2'b00; cmp_cc = 3'd5; set_flags(1'b1, 1'b0, 1'b1);
    br_valid = 1'b1; br_cc = 3'd5; br_tf = 1'b0;
    #1;
    check_value("same_cycle_br_ready", {7'd0, br_ready}, 8'h01);
    @(posedge clk); #1;
    check_value("same_cycle_resp_valid", {7'd0, br_resp_valid}, 8'h01);
    check_value("same_cycle_taken", {7'd0, br_taken}, 8'h01);
    check_value("same_cycle_cc_before", cc_out, 8'h81);
    @(negedge clk); cmp_valid = 1'b0; br_valid = 1'b0;
    @(posedge clk); #1;
    check_value("same_cycle_cc_after", cc_out, 8'hA1);

    // bc1t on cc5 (now set) is taken; bc1t on cc4 (clear) is not
    @(negedge clk); br_valid = 1'b1; br_cc = 3'd5; br_tf = 1'b1;
    @(posedge clk); #1;
    check_value("bc1t_set_taken", {7'd0, br_taken}, 8'h01);
    @(negedge clk); br_cc = 3'd4;
    @(posedge clk); #1;
    check_value("bc1t_clear_taken", {7'd0, br_taken}, 8'h00);
    @(negedge clk); br_valid = 1'b0;

    // Reserved op writes 0 even with all flags set
    @(negedge clk);
    cmp_valid = 1'b1; cmp_op = 2'b11; cmp_cc = 3'd0; set_flags(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk); cmp_valid = 1'b0;
    @(posedge clk); #1;
    check_value("reserved_op_zero", cc_out, 8'hA0);

    // Async reset while S1 holds a write to cc1 and a branch response is pending
    @(negedge clk);
    cmp_valid = 1'b1; cmp_op = 2'b01; cmp_cc = 3'd1; set_flags(1'b0, 1'b1, 1'b1);
    br_valid = 1'b1; br_cc = 3'd7; br_tf = 1'b1;
    @(posedge clk); #1;
    check_value("pre_reset_resp", {7'd0, br_resp_valid}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    check_value("async_reset_cc", cc_out, 8'h00);
    check_value("async_reset_resp", {7'd0, br_resp_valid}, 8'h00);
    @(negedge clk);
    cmp_valid = 1'b0; br_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check_value("no_writeback_after_reset", cc_out, 8'h00);

    // Compare LT to cc2 squashed by flush the following cycle
    @(negedge clk);
    cmp_valid = 1'b1; cmp_op = 2'b01; cmp_cc = 3'd2; set_flags(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmp_valid = 1'b0; flush = 1'b1; br_valid = 1'b1; br_cc = 3'd6;
    #1;
    check_value("flush_cmp_ready", {7'd0, cmp_ready}, 8'h00);
    check_value("flush_br_ready", {7'd0, br_ready}, 8'h00);
    @(posedge clk); #1;
    check_value("flush_no_write", cc_out, 8'h00);
    check_value("flush_no_branch", {7'd0, br_resp_valid}, 8'h00);
    @(negedge clk); flush = 1'b0; br_valid = 1'b0;
    @(posedge clk); #1;
    check_value("flush_still_clear", cc_out, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
